// File: rtl/life_matrix_scan.sv
// ============================================================================
//  life_matrix_scan : row-multiplexed 8x8 LED driver for the Game of Life board
//  Revision 1.0
// ============================================================================
`default_nettype none

module life_matrix_scan #(
  parameter int DWELL = 4,
  parameter int BLANK = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] grid,
  input  logic        enable,
  output logic [7:0]  row_sel,
  output logic [7:0]  col_data,
  output logic [2:0]  row_idx,
  output logic        frame_start
);

  localparam int CMAX = (DWELL > BLANK) ? ((DWELL > 2) ? DWELL : 2)
                                        : ((BLANK > 2) ? BLANK : 2);
  localparam int CW   = $clog2(CMAX);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK > 0) ? BLANK - 1 : 0);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_ACTIVE = 2'd2;
  localparam logic [1:0] S_BLANK  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [2:0]    row_q, row_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   buf_q, buf_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      row_q   <= 3'd0;
      cnt_q   <= '0;
      buf_q   <= 64'd0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    if (!enable) begin
      // Frame buffer is deliberately kept; only the scan position is dropped.
      state_d = S_IDLE;
      row_d   = 3'd0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_LOAD;
          row_d   = 3'd0;
          cnt_d   = '0;
        end
        S_LOAD: begin
          buf_d   = grid;
          row_d   = 3'd0;
          cnt_d   = '0;
          state_d = S_ACTIVE;
        end
        S_ACTIVE: begin
          if (cnt_q == DWELL_LAST) begin
            cnt_d = '0;
            if (BLANK > 0) begin
              state_d = S_BLANK;
            end else if (row_q == 3'd7) begin
              state_d = S_LOAD;
              row_d   = 3'd0;
            end else begin
              row_d   = row_q + 3'd1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            cnt_d = '0;
            if (row_q == 3'd7) begin
              state_d = S_LOAD;
              row_d   = 3'd0;
            end else begin
              state_d = S_ACTIVE;
              row_d   = row_q + 3'd1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          row_d   = 3'd0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs depend on registered state only, so grid never reaches the pins.
  always_comb begin
    row_sel     = 8'd0;
    col_data    = 8'd0;
    row_idx     = (state_q == S_IDLE) ? 3'd0 : row_q;
    frame_start = (state_q == S_LOAD);
    if (state_q == S_ACTIVE) begin
      row_sel  = 8'd1 << row_q;
      col_data = buf_q[{row_q, 3'b000} +: 8];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_life_matrix_scan.sv
// ============================================================================
//  tb_life_matrix_scan : randomized self-checking bench with a frame-timeline model
//  Revision 1.0
// ============================================================================
`default_nettype none

module tb_life_matrix_scan;

  localparam int DWELL = 4;
  localparam int BLANK = 1;
  localparam int P     = DWELL + BLANK;
  localparam int FRAME = 1 + 8 * P;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic [63:0] grid = '1;
  logic [7:0]  row_sel, col_data, row_sel0, col_data0;
  logic [2:0]  row_idx, row_idx0;
  logic        frame_start, frame_start0;

  life_matrix_scan #(.DWELL(DWELL), .BLANK(BLANK)) u_dut (
    .clk(clk), .reset(reset), .grid(grid), .enable(enable),
    .row_sel(row_sel), .col_data(col_data), .row_idx(row_idx),
    .frame_start(frame_start)
  );

  life_matrix_scan #(.DWELL(4), .BLANK(0)) u_dut_b0 (
    .clk(clk), .reset(reset), .grid(grid), .enable(enable),
    .row_sel(row_sel0), .col_data(col_data0), .row_idx(row_idx0),
    .frame_start(frame_start0)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: idle flag plus position within the frame timeline
  // (t=0 is the capture cycle, then 8 slots of P cycles each).
  logic        m_idle  = 1'b1;
  int          m_t     = 0;
  logic [63:0] m_board = 64'd0;

  int cyc = 0;
  logic meas = 1'b0;
  int last_fs = -1, last_fs0 = -1, zeros0 = 0;
  int fcount = 0;
  logic tblchk = 1'b0;
  logic [7:0] tbl [8] = '{8'h28, 8'h3C, 8'h34, 8'h00, 8'h24, 8'h64, 8'h12, 8'h04};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_edge();
    if (reset || !enable) m_idle = 1'b1;
    else if (m_idle) begin
      m_idle = 1'b0;
      m_t    = 0;
    end else if (m_t == 0) begin
      m_board = grid;
      m_t     = 1;
    end else begin
      m_t = (m_t == FRAME - 1) ? 0 : m_t + 1;
    end
  endtask

  task automatic check_outputs();
    logic [7:0] e_sel, e_col;
    logic [2:0] e_idx;
    logic       e_fs;
    int k, r;
    e_sel = 8'd0; e_col = 8'd0; e_idx = 3'd0; e_fs = 1'b0;
    if (!m_idle) begin
      if (m_t == 0) e_fs = 1'b1;
      else begin
        k = m_t - 1;
        r = k / P;
        e_idx = 3'(r);
        if ((k % P) < DWELL) begin
          e_sel = 8'(1 << r);
          e_col = m_board[8*r +: 8];
        end
      end
    end
    check("row_sel", 64'(row_sel), 64'(e_sel));
    check("col_data", 64'(col_data), 64'(e_col));
    check("row_idx", 64'(row_idx), 64'(e_idx));
    check("frame_start", 64'(frame_start), 64'(e_fs));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    check_outputs();
    if (frame_start) fcount++;
    if (tblchk && row_sel != 8'd0) begin
      if (fcount == 1) check("frame1_row_data", 64'(col_data), 64'(tbl[row_idx]));
      if (fcount == 2) check("frame2_all_ones", 64'(col_data), 64'hFF);
    end
    if (meas) begin
      if (frame_start) begin
        if (last_fs >= 0) check("period", 64'(cyc - last_fs), 64'd41);
        last_fs = cyc;
      end
      if (frame_start0) begin
        if (last_fs0 >= 0) begin
          check("period_noblank", 64'(cyc - last_fs0), 64'd33);
          check("dark_cycles_noblank", 64'(zeros0), 64'd1);
        end
        last_fs0 = cyc;
        zeros0   = 0;
      end
      if (row_sel0 == 8'd0) zeros0++;
    end
  endtask

  initial begin
    // Reset held with everything asserted: outputs must stay dark.
    #1;
    check_outputs();
    repeat (3) cycle();
    reset = 1'b0;
    grid  = 64'h0412_6424_0034_3C28;

    // Known board, mid-frame grid change, period measurement over 3 frames.
    tblchk = 1'b1;
    meas   = 1'b1;
    fcount = 0;
    for (int i = 0; i < 3 * FRAME + 4; i++) begin
      cycle();
      if (fcount == 1 && !m_idle && m_t == 1 + 3 * P) grid = '1;
    end
    tblchk = 1'b0;
    meas   = 1'b0;
    check("frames_seen", 64'(fcount), 64'd4);

    // Drop enable during row 5, then re-enable: restart from LOAD at row 0.
    grid = 64'hA5A5_5A5A_0F0F_F0F0;
    for (int i = 0; i < 2 * FRAME && !(!m_idle && m_t == 2 + 5 * P); i++) cycle();
    check("reached_row5", 64'(row_idx), 64'd5);
    enable = 1'b0;
    cycle();
    check("disabled_row_idx", 64'(row_idx), 64'd0);
    enable = 1'b1;
    cycle();
    check("reenable_load", 64'(frame_start), 64'd1);
    cycle();
    check("reenable_row0", 64'(row_sel), 64'h01);

    // Asynchronous reset off the clock edge while a row is lit.
    for (int i = 0; i < 2 * FRAME && !(!m_idle && m_t == 2 + 2 * P); i++) cycle();
    #3;
    reset = 1'b1;
    m_idle = 1'b1;
    #1;
    check_outputs();
    cycle();
    cycle();
    reset = 1'b0;
    for (int i = 0; i < FRAME + 3; i++) cycle();

    // Randomized phase: grid churn, occasional enable drops and resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) grid = {$urandom, $urandom};
      enable = ($urandom_range(0, 39) != 0);
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 149) == 0) begin
        reset  = 1'b1;
        m_idle = 1'b1;
        #1;
        check_outputs();
      end
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
